bcd_countdown_timer: RTL and testbench

//  Parametrised mm:ss BCD countdown timer with overtime count-up for the GPIO display chain.

---
 rtl/bcd_countdown_timer.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer that rolls into a saturating overtime count-up with a minus sign.
// Optional blinking of the overtime digits is enabled by defining TIMER_BLINK_EN.
module bcd_countdown_timer #(
    parameter int START_MIN = 20,
    parameter int START_SEC = 0,
    parameter int MAX_MIN   = 99,
    parameter int DIGIT_W   = 5
) (
    input  logic               input_clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start_elapse,
    input  logic               stop_elapse,
    input  logic               load,
    input  logic [3:0]         load_H_min,
    input  logic [3:0]         load_L_min,
    input  logic [3:0]         load_H_sec,
    input  logic [3:0]         load_L_sec,
    output logic [DIGIT_W-1:0] out_H_min,
    output logic [DIGIT_W-1:0] out_L_min,
    output logic [DIGIT_W-1:0] out_H_sec,
    output logic [DIGIT_W-1:0] out_L_sec,
    output logic [DIGIT_W-1:0] out_sign,
    output logic               expired,
    output logic               zero_pulse
);

    typedef enum logic {ST_DOWN, ST_OVER} state_t;

    localparam logic [3:0] RST_HM = 4'(START_MIN / 10);
    localparam logic [3:0] RST_LM = 4'(START_MIN % 10);
    localparam logic [3:0] RST_HS = 4'(START_SEC / 10);
    localparam logic [3:0] RST_LS = 4'(START_SEC % 10);
    localparam logic [3:0] MAX_HM = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_LM = 4'(MAX_MIN % 10);
    localparam logic [7:0] MAX_MIN_B = 8'(MAX_MIN);
    localparam logic [DIGIT_W-1:0] GLYPH_BLANK = DIGIT_W'(5'b11111);
    localparam logic [DIGIT_W-1:0] GLYPH_MINUS = DIGIT_W'(5'b10001);

    state_t     r_state, w_state_next;
    logic [3:0] r_h_min, r_l_min, r_h_sec, r_l_sec;
    logic [3:0] w_h_min_next, w_l_min_next, w_h_sec_next, w_l_sec_next;
    logic       r_stopped, w_stopped_next;
    logic       r_zero_pulse, w_zero_pulse_next;
    logic       w_count, w_at_zero, w_at_max, w_blank;

    logic [3:0] w_ld_lm, w_ld_hs, w_ld_ls;
    logic [7:0] w_ld_minutes;
    logic       w_ld_sat;

    assign w_count   = tick & start_elapse & ~r_stopped;
    assign w_at_zero = (r_h_min == 4'd0) && (r_l_min == 4'd0) &&
                       (r_h_sec == 4'd0) && (r_l_sec == 4'd0);
    assign w_at_max  = (r_h_min == MAX_HM) && (r_l_min == MAX_LM) &&
                       (r_h_sec == 4'd5) && (r_l_sec == 4'd9);

    // Out-of-range preset digits are clamped; a preset past MAX_MIN snaps to MAX_MIN:59.
    assign w_ld_lm      = (load_L_min > 4'd9) ? 4'd9 : load_L_min;
    assign w_ld_hs      = (load_H_sec > 4'd5) ? 4'd5 : load_H_sec;
    assign w_ld_ls      = (load_L_sec > 4'd9) ? 4'd9 : load_L_sec;
    assign w_ld_minutes = ({4'd0, load_H_min} * 8'd10) + {4'd0, w_ld_lm};
    assign w_ld_sat     = w_ld_minutes > MAX_MIN_B;

`ifdef TIMER_BLINK_EN
    logic r_blink, w_blink_next;
    assign w_blank = r_blink;
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_h_min_next      = r_h_min;
        w_l_min_next      = r_l_min;
        w_h_sec_next      = r_h_sec;
        w_l_sec_next      = r_l_sec;
        w_stopped_next    = r_stopped;
        w_zero_pulse_next = 1'b0;
`ifdef TIMER_BLINK_EN
        w_blink_next      = r_blink;
`endif
        if (load) begin
            w_state_next   = ST_DOWN;
            w_stopped_next = 1'b0;
`ifdef TIMER_BLINK_EN
            w_blink_next   = 1'b0;
`endif
            if (w_ld_sat) begin
                w_h_min_next = MAX_HM;
                w_l_min_next = MAX_LM;
                w_h_sec_next = 4'd5;
                w_l_sec_next = 4'd9;
            end else begin
                w_h_min_next = load_H_min;
                w_l_min_next = w_ld_lm;
                w_h_sec_next = w_ld_hs;
                w_l_sec_next = w_ld_ls;
            end
        end else if (stop_elapse) begin
            w_stopped_next = 1'b1;
        end else if (w_count) begin
            case (r_state)
                ST_DOWN: begin
                    if (w_at_zero) begin
                        w_state_next      = ST_OVER;
                        w_zero_pulse_next = 1'b1;
`ifdef TIMER_BLINK_EN
                        w_blink_next      = 1'b0;
`endif
                    end else if (r_l_sec != 4'd0) begin
                        w_l_sec_next = r_l_sec - 4'd1;
                    end else begin
                        w_l_sec_next = 4'd9;
                        if (r_h_sec != 4'd0) begin
                            w_h_sec_next = r_h_sec - 4'd1;
                        end else begin
                            w_h_sec_next = 4'd5;
                            if (r_l_min != 4'd0) begin
                                w_l_min_next = r_l_min - 4'd1;
                            end else begin
                                w_l_min_next = 4'd9;
                                w_h_min_next = r_h_min - 4'd1;
                            end
                        end
                    end
                end
                ST_OVER: begin
`ifdef TIMER_BLINK_EN
                    w_blink_next = ~r_blink;
`endif
                    if (!w_at_max) begin
                        if (r_l_sec != 4'd9) begin
                            w_l_sec_next = r_l_sec + 4'd1;
                        end else begin
                            w_l_sec_next = 4'd0;
                            if (r_h_sec != 4'd5) begin
                                w_h_sec_next = r_h_sec + 4'd1;
                            end else begin
                                w_h_sec_next = 4'd0;
                                if (r_l_min != 4'd9) begin
                                    w_l_min_next = r_l_min + 4'd1;
                                end else begin
                                    w_l_min_next = 4'd0;
                                    w_h_min_next = r_h_min + 4'd1;
                                end
                            end
                        end
                    end
                end
                default: w_state_next = ST_DOWN;
            endcase
        end
    end

    always_ff @(posedge input_clk) begin
        if (reset) begin
            r_state      <= ST_DOWN;
            r_h_min      <= RST_HM;
            r_l_min      <= RST_LM;
            r_h_sec      <= RST_HS;
            r_l_sec      <= RST_LS;
            r_stopped    <= 1'b0;
            r_zero_pulse <= 1'b0;
`ifdef TIMER_BLINK_EN
            r_blink      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_h_min      <= w_h_min_next;
            r_l_min      <= w_l_min_next;
            r_h_sec      <= w_h_sec_next;
            r_l_sec      <= w_l_sec_next;
            r_stopped    <= w_stopped_next;
            r_zero_pulse <= w_zero_pulse_next;
`ifdef TIMER_BLINK_EN
            r_blink      <= w_blink_next;
`endif
        end
    end

    // Digit order: 0 = minutes tens ... 3 = seconds units.
    logic [3:0]         w_digit [4];
    logic [DIGIT_W-1:0] w_glyph [4];

    assign w_digit[0] = r_h_min;
    assign w_digit[1] = r_l_min;
    assign w_digit[2] = r_h_sec;
    assign w_digit[3] = r_l_sec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign w_glyph[gi] = w_blank ? GLYPH_BLANK
                                         : {{(DIGIT_W-4){1'b0}}, w_digit[gi]};
        end
    endgenerate

    assign out_H_min  = w_glyph[0];
    assign out_L_min  = w_glyph[1];
    assign out_H_sec  = w_glyph[2];
    assign out_L_sec  = w_glyph[3];
    assign out_sign   = (r_state == ST_OVER) ? GLYPH_MINUS : GLYPH_BLANK;
    assign expired    = (r_state == ST_OVER);
    assign zero_pulse = r_zero_pulse;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (default and MAX_MIN=1) on shared stimulus,
// checked against a seconds-based reference model plus directed literal expectations.
module tb_bcd_countdown_timer;

    logic input_clk = 1'b0;
    always #5 input_clk = ~input_clk;

    logic reset = 1'b1, tick = 1'b0, start_elapse = 1'b0, stop_elapse = 1'b0, load = 1'b0;
    logic [3:0] ld_hm = 4'd0, ld_lm = 4'd0, ld_hs = 4'd0, ld_ls = 4'd0;
    logic [4:0] a_hm, a_lm, a_hs, a_ls, a_sign, b_hm, b_lm, b_hs, b_ls, b_sign;
    logic       a_exp, a_zp, b_exp, b_zp;

    bcd_countdown_timer #(.START_MIN(20), .START_SEC(0), .MAX_MIN(99), .DIGIT_W(5)) dut_a (
        .input_clk(input_clk), .reset(reset), .tick(tick), .start_elapse(start_elapse),
        .stop_elapse(stop_elapse), .load(load), .load_H_min(ld_hm), .load_L_min(ld_lm),
        .load_H_sec(ld_hs), .load_L_sec(ld_ls), .out_H_min(a_hm), .out_L_min(a_lm),
        .out_H_sec(a_hs), .out_L_sec(a_ls), .out_sign(a_sign), .expired(a_exp),
        .zero_pulse(a_zp));

    bcd_countdown_timer #(.START_MIN(0), .START_SEC(2), .MAX_MIN(1), .DIGIT_W(5)) dut_b (
        .input_clk(input_clk), .reset(reset), .tick(tick), .start_elapse(start_elapse),
        .stop_elapse(stop_elapse), .load(load), .load_H_min(ld_hm), .load_L_min(ld_lm),
        .load_H_sec(ld_hs), .load_L_sec(ld_ls), .out_H_min(b_hm), .out_L_min(b_lm),
        .out_H_sec(b_hs), .out_L_sec(b_ls), .out_sign(b_sign), .expired(b_exp),
        .zero_pulse(b_zp));

    int checks = 0;
    int errors = 0;

    // Reference model: time held as plain seconds per instance.
    int m_val   [2] = '{1200, 2};
    int m_max   [2] = '{99, 1};
    int m_start [2] = '{1200, 2};
    bit m_over  [2] = '{0, 0};
    bit m_stop  [2] = '{0, 0};
    bit m_zp    [2] = '{0, 0};
    bit m_blink [2] = '{0, 0};

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int lim;
            lim = m_max[k] * 60 + 59;
            m_zp[k] = 1'b0;
            if (reset) begin
                m_val[k] = m_start[k]; m_over[k] = 0; m_stop[k] = 0; m_blink[k] = 0;
            end else if (load) begin
                int lm, hs, ls, mins;
                lm = (ld_lm > 9) ? 9 : int'(ld_lm);
                hs = (ld_hs > 5) ? 5 : int'(ld_hs);
                ls = (ld_ls > 9) ? 9 : int'(ld_ls);
                mins = int'(ld_hm) * 10 + lm;
                m_val[k] = (mins > m_max[k]) ? lim : (mins * 60 + hs * 10 + ls);
                m_over[k] = 0; m_stop[k] = 0; m_blink[k] = 0;
            end else if (stop_elapse) begin
                m_stop[k] = 1'b1;
            end else if (tick && start_elapse && !m_stop[k]) begin
                if (!m_over[k]) begin
                    if (m_val[k] == 0) begin
                        m_over[k] = 1; m_zp[k] = 1; m_blink[k] = 0;
                    end else begin
                        m_val[k] = m_val[k] - 1;
                    end
                end else begin
                    m_blink[k] = !m_blink[k];
                    if (m_val[k] < lim) m_val[k] = m_val[k] + 1;
                end
            end
        end
    endtask

    function automatic logic [26:0] model_vec(int k);
        int mm, ss;
        logic [4:0] hm, lm, hs, ls;
        mm = m_val[k] / 60;
        ss = m_val[k] % 60;
        hm = 5'(mm / 10); lm = 5'(mm % 10); hs = 5'(ss / 10); ls = 5'(ss % 10);
`ifdef TIMER_BLINK_EN
        if (m_blink[k]) begin
            hm = 5'h1F; lm = 5'h1F; hs = 5'h1F; ls = 5'h1F;
        end
`endif
        return {hm, lm, hs, ls, (m_over[k] ? 5'b10001 : 5'b11111), m_over[k], m_zp[k]};
    endfunction

    function automatic logic [26:0] dut_vec(int k);
        if (k == 0) return {a_hm, a_lm, a_hs, a_ls, a_sign, a_exp, a_zp};
        return {b_hm, b_lm, b_hs, b_ls, b_sign, b_exp, b_zp};
    endfunction

    // Displayed time as four BCD nibbles (mm:ss), e.g. 16'h0959.
    function automatic logic [15:0] shown(int k);
        if (k == 0) return {a_hm[3:0], a_lm[3:0], a_hs[3:0], a_ls[3:0]};
        return {b_hm[3:0], b_lm[3:0], b_hs[3:0], b_ls[3:0]};
    endfunction

    task automatic cycle();
        @(posedge input_clk);
        #1;
        model_step();
        $display("t=%0t A=%h sign=%b exp=%b zp=%b | B=%h exp=%b", $time, shown(0), a_sign,
                 a_exp, a_zp, shown(1), b_exp);
    endtask

    task automatic set_load(input logic [3:0] hm, lm, hs, ls);
        ld_hm = hm; ld_lm = lm; ld_hs = hs; ld_ls = ls;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; start_elapse = 1'b1;
        cycle(); cycle();
        reset = 1'b0; tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h2000 || a_sign !== 5'b11111 || a_exp !== 1'b0 || a_zp !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got %h sign=%b exp=%b zp=%b, want 2000 11111 0 0",
                     shown(0), a_sign, a_exp, a_zp);
        end
        checks++;
        if (dut_vec(1) !== model_vec(1) || shown(1) !== 16'h0002) begin
            errors++;
            $display("FAIL reset_b: got %h want %h", dut_vec(1), model_vec(1));
        end
    endtask

    task automatic test_count_down();
        logic [15:0] exp_tab [3];
        exp_tab = '{16'h0002, 16'h0001, 16'h0000};
        set_load(4'd0, 4'd0, 4'd0, 4'd3);
        start_elapse = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; cycle(); tick = 1'b0;
            checks++;
            if (shown(0) !== exp_tab[i] || a_exp !== 1'b0 || a_sign !== 5'b11111) begin
                errors++;
                $display("FAIL countdown_%0d: got %h exp=%b sign=%b, want %h 0 11111",
                         i, shown(0), a_exp, a_sign, exp_tab[i]);
            end
        end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0000 || a_exp !== 1'b1 || a_zp !== 1'b1 || a_sign !== 5'b10001) begin
            errors++;
            $display("FAIL enter_over: got %h exp=%b zp=%b sign=%b, want 0000 1 1 10001",
                     shown(0), a_exp, a_zp, a_sign);
        end
        cycle();
        checks++;
        if (a_zp !== 1'b0 || a_exp !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse_width: got zp=%b exp=%b, want 0 1", a_zp, a_exp);
        end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0001 || dut_vec(0) !== model_vec(0)) begin
            errors++;
            $display("FAIL over_count: got %h want 0001 (vec %h vs %h)", shown(0),
                     dut_vec(0), model_vec(0));
        end
    endtask

    task automatic test_load();
        set_load(4'd1, 4'd0, 4'd0, 4'd0);
        checks++;
        if (shown(0) !== 16'h1000 || a_exp !== 1'b0 || a_sign !== 5'b11111) begin
            errors++;
            $display("FAIL load_clears_over: got %h exp=%b sign=%b, want 1000 0 11111",
                     shown(0), a_exp, a_sign);
        end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0959) begin
            errors++;
            $display("FAIL borrow_10_00: got %h want 0959", shown(0));
        end
        set_load(4'd0, 4'd1, 4'd0, 4'd0);
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0059) begin
            errors++;
            $display("FAIL borrow_01_00: got %h want 0059", shown(0));
        end
        // Load coinciding with a tick: the tick must be ignored.
        tick = 1'b1; set_load(4'd0, 4'd4, 4'd3, 4'd2); tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0432) begin
            errors++;
            $display("FAIL load_with_tick: got %h want 0432", shown(0));
        end
    endtask

    task automatic test_stop();
        set_load(4'd0, 4'd5, 4'd0, 4'd0);
        stop_elapse = 1'b1; tick = 1'b1; cycle(); stop_elapse = 1'b0;
        checks++;
        if (shown(0) !== 16'h0500) begin
            errors++;
            $display("FAIL stop_with_tick: got %h want 0500", shown(0));
        end
        cycle(); cycle(); cycle();
        tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0500) begin
            errors++;
            $display("FAIL stop_sticky: got %h want 0500", shown(0));
        end
        set_load(4'd0, 4'd5, 4'd0, 4'd0);
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++;
        if (shown(0) !== 16'h0459) begin
            errors++;
            $display("FAIL load_unstops: got %h want 0459", shown(0));
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1; cycle(); reset = 1'b0;
        start_elapse = 1'b1; tick = 1'b1;
        for (int i = 0; i < 121; i++) cycle();
        tick = 1'b0;
        checks++;
        if (shown(1) !== 16'h0158 || b_exp !== 1'b1) begin
            errors++;
            $display("FAIL over_0158: got %h exp=%b want 0158 1", shown(1), b_exp);
        end
        tick = 1'b1; cycle();
        checks++;
        if (shown(1) !== 16'h0159) begin
            errors++;
            $display("FAIL over_0159: got %h want 0159", shown(1));
        end
        cycle(); tick = 1'b0;
        checks++;
        if (shown(1) !== 16'h0159 || b_sign !== 5'b10001) begin
            errors++;
            $display("FAIL saturate: got %h sign=%b want 0159 10001", shown(1), b_sign);
        end
    endtask

    task automatic test_clamp();
        set_load(4'd0, 4'd0, 4'd7, 4'd12);
        checks++;
        if (shown(0) !== 16'h0059 || shown(1) !== 16'h0059) begin
            errors++;
            $display("FAIL clamp_sec: got A=%h B=%h want 0059", shown(0), shown(1));
        end
        set_load(4'd12, 4'd3, 4'd1, 4'd1);
        checks++;
        if (shown(0) !== 16'h9959 || shown(1) !== 16'h0159) begin
            errors++;
            $display("FAIL clamp_min: got A=%h B=%h want 9959/0159", shown(0), shown(1));
        end
        set_load(4'd0, 4'd0, 4'd0, 4'd0);
        tick = 1'b1; cycle(); cycle(); tick = 1'b0;
        reset = 1'b1; cycle(); reset = 1'b0;
        checks++;
        if (shown(0) !== 16'h2000 || a_exp !== 1'b0 || a_sign !== 5'b11111) begin
            errors++;
            $display("FAIL reset_mid_over: got %h exp=%b sign=%b want 2000 0 11111",
                     shown(0), a_exp, a_sign);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 499) == 0);
            load         = ($urandom_range(0, 39) == 0);
            stop_elapse  = ($urandom_range(0, 99) == 0);
            start_elapse = ($urandom_range(0, 9) != 0);
            tick         = ($urandom_range(0, 9) < 7);
            ld_hm = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            ld_lm = 4'($urandom_range(0, 15));
            ld_hs = 4'($urandom_range(0, 7));
            ld_ls = 4'($urandom_range(0, 11));
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec(k) !== model_vec(k)) begin
                    errors++;
                    $display("FAIL random_%0d dut%0d: got %h want %h", n, k, dut_vec(k),
                             model_vec(k));
                end
            end
        end
        reset = 1'b0; load = 1'b0; stop_elapse = 1'b0; tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_down();
        test_load();
        test_stop();
        test_saturation();
        test_clamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
